// File: rtl/trd_pkg.sv
// Shared types, sizes and the slot-allocation helper for the thread scheduler.
package trd_pkg;

  localparam int NUM_TRD       = 8;
  localparam int TRD_W         = 3;
  localparam int MISS_WAIT_DEF = 4;
  localparam int CTR_W         = 4;

  typedef logic [TRD_W-1:0]   trd_id_t;
  typedef logic [NUM_TRD-1:0] trd_mask_t;

  // Lowest slot >= 1 whose bit is clear; 0 when slots 1..NUM_TRD-1 are all set.
  function automatic trd_id_t first_zero_from1(input trd_mask_t mask);
    trd_id_t id;
    id = '0;
    for (int i = NUM_TRD - 1; i >= 1; i--) begin
      if (!mask[i]) id = trd_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/trd_sched_rr_pick.sv
// Combinational round-robin picker: first set bit strictly after ptr, wrapping,
// so ptr itself wins only when it is the sole requester.
module rr_pick
  import trd_pkg::*;
(
  input  trd_mask_t mask,
  input  trd_id_t   ptr,
  output trd_id_t   gnt_id,
  output logic      gnt_any
);

  trd_id_t idx;

  // Walk from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    gnt_id  = ptr;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = NUM_TRD; i >= 1; i--) begin
      idx = ptr + trd_id_t'(i);
      if (mask[idx]) begin
        gnt_id  = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trd_sched.sv
// Barrel-thread scheduler: thread masks, miss parking, slot allocation, fetch pick.
// Optional macro TRD_SCHED_PRIO_EN gives thread 0 priority grants over round-robin.
module trd_sched
  import trd_pkg::*;
#(
  parameter int MISS_WAIT = MISS_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              kill,
  input  logic              sleep,
  input  logic              wake,
  input  logic [TRD_W-1:0]  obj_trd,
  input  logic              init_trd,
  input  logic              i_miss,
  input  logic [TRD_W-1:0]  i_miss_trd,
  input  logic              d_miss,
  input  logic [TRD_W-1:0]  d_miss_trd,
  output logic [TRD_W-1:0]  trd_if,
  output logic              trd_if_vld,
  output logic [TRD_W-1:0]  new_trd_id,
  output logic [NUM_TRD-1:0] valid_trd,
  output logic [NUM_TRD-1:0] run_trd,
  output logic [NUM_TRD-1:0] park_trd,
  output logic              trd_full,
  output logic              trd_of
);

  trd_mask_t valid_reg, valid_next;
  trd_mask_t run_reg, run_next;
  trd_mask_t park_reg, park_next;
  trd_mask_t eligible;
  trd_id_t   ptr_reg, trd_if_reg;
  logic      trd_if_vld_reg, trd_of_reg;
  trd_id_t   rr_id, pick_id;
  logic      rr_any, pick_any, prio_hit;

  assign eligible   = run_reg & ~park_reg & valid_reg;
  assign trd_full   = &valid_reg[NUM_TRD-1:1];
  assign new_trd_id = first_zero_from1(valid_reg);

  rr_pick u_rr_pick (
    .mask    (eligible),
    .ptr     (ptr_reg),
    .gnt_id  (rr_id),
    .gnt_any (rr_any)
  );

`ifdef TRD_SCHED_PRIO_EN
  assign prio_hit = eligible[0] && !(trd_if_vld_reg && trd_if_reg == '0);
`else
  assign prio_hit = 1'b0;
`endif

  assign pick_id  = prio_hit ? '0 : rr_id;
  assign pick_any = prio_hit | rr_any;

  generate
    for (genvar gi = 0; gi < NUM_TRD; gi++) begin : gen_trd
      logic             hit_kill, hit_sleep, hit_wake, hit_init, hit_miss;
      logic             v_n, r_n, p_n;
      logic [CTR_W-1:0] ctr_reg, ctr_next;

      assign hit_kill  = kill  && (obj_trd == trd_id_t'(gi));
      assign hit_sleep = sleep && (obj_trd == trd_id_t'(gi));
      assign hit_wake  = wake  && (obj_trd == trd_id_t'(gi));
      assign hit_init  = init_trd && !trd_full && (new_trd_id == trd_id_t'(gi));
      assign hit_miss  = valid_reg[gi] &&
                         ((i_miss && i_miss_trd == trd_id_t'(gi)) ||
                          (d_miss && d_miss_trd == trd_id_t'(gi)));

      // Park countdown first, then a fresh miss reloads it, then kill overrides everything.
      always_comb begin
        v_n      = valid_reg[gi];
        r_n      = run_reg[gi];
        p_n      = park_reg[gi];
        ctr_next = ctr_reg;
        if (ctr_reg != '0) begin
          ctr_next = ctr_reg - 1'b1;
          if (ctr_reg == CTR_W'(1)) p_n = 1'b0;
        end
        if (hit_miss) begin
          p_n      = 1'b1;
          ctr_next = CTR_W'(MISS_WAIT);
        end
        if (hit_kill) begin
          v_n      = 1'b0;
          r_n      = 1'b0;
          p_n      = 1'b0;
          ctr_next = '0;
        end else if (hit_sleep) begin
          r_n = 1'b0;
        end else if (hit_wake && valid_reg[gi]) begin
          r_n = 1'b1;
        end
        if (hit_init) begin
          v_n = 1'b1;
          r_n = 1'b1;
        end
      end

      assign valid_next[gi] = v_n;
      assign run_next[gi]   = r_n;
      assign park_next[gi]  = p_n;

      always_ff @(posedge clk) begin
        if (!rst_n) ctr_reg <= '0;
        else        ctr_reg <= ctr_next;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg      <= trd_mask_t'(1);
      run_reg        <= trd_mask_t'(1);
      park_reg       <= '0;
      ptr_reg        <= '0;
      trd_if_reg     <= '0;
      trd_if_vld_reg <= 1'b0;
      trd_of_reg     <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      run_reg   <= run_next;
      park_reg  <= park_next;
      if (init_trd && trd_full) trd_of_reg <= 1'b1;
      if (!stall) begin
        if (pick_any) begin
          trd_if_reg     <= pick_id;
          trd_if_vld_reg <= 1'b1;
          if (!prio_hit) ptr_reg <= pick_id;
        end else begin
          trd_if_vld_reg <= 1'b0;
        end
      end
    end
  end

  assign trd_if     = trd_if_reg;
  assign trd_if_vld = trd_if_vld_reg;
  assign valid_trd  = valid_reg;
  assign run_trd    = run_reg;
  assign park_trd   = park_reg;
  assign trd_of     = trd_of_reg;

endmodule

// File: doc/trd_sched.md
Name: trd_sched

Overview:
- Per-cycle thread scheduler for the barrel-threaded ThreadKraken pipeline.
- Owns the valid/run/park masks for all hardware threads and picks the thread that fetches next (trd_if), using round-robin over eligible threads.
- Applies thread ops from writeback (kill/sleep/wake), allocates slots for new threads, and parks threads for a fixed time after an I- or D-side miss.
- Sits between writeback/flush logic and the fetch stage.

Parameters:
- NUM_TRD, 8, number of hardware thread slots (power of two).
- TRD_W, 3, thread id width, log2(NUM_TRD).
- MISS_WAIT, 4, cycles a thread stays parked after a miss (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  pipeline stall; hold the schedule
- kill  in  1  kill thread obj_trd (from wb)
- sleep  in  1  clear run bit of obj_trd
- wake  in  1  set run bit of obj_trd
- obj_trd  in  TRD_W  target thread of kill/sleep/wake
- init_trd  in  1  request to allocate a new thread
- i_miss  in  1  instruction miss
- i_miss_trd  in  TRD_W  thread that took the I-miss
- d_miss  in  1  data miss
- d_miss_trd  in  TRD_W  thread that took the D-miss
- trd_if  out  TRD_W  thread selected for fetch
- trd_if_vld  out  1  trd_if is a real slot (0 = bubble)
- new_trd_id  out  TRD_W  slot the next init will use
- valid_trd  out  NUM_TRD  allocated threads
- run_trd  out  NUM_TRD  runnable threads
- park_trd  out  NUM_TRD  miss-parked threads
- trd_full  out  1  no free slot
- trd_of  out  1  sticky: init requested while full

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- Reset values: valid_trd=1, run_trd=1, park_trd=0, park counters=0, rr pointer=0, trd_if=0, trd_if_vld=0, trd_of=0, trd_full=0, new_trd_id=1.
- Eligibility: eligible = run_trd & ~park_trd & valid_trd, computed from registered state.
- Selection:
  - Pick the first eligible index strictly after the pointer, wrapping; the pointer's own index is picked only if it is the sole eligible thread.
  - trd_if/trd_if_vld are registered, so a selection shows up one cycle after the state it was computed from.
  - On a grant the pointer moves to the granted id.
  - No eligible thread: trd_if_vld=0, and trd_if and the pointer hold.
- stall=1: trd_if, trd_if_vld and the pointer hold. Mask, park and op updates still apply.
- Thread ops, applied next cycle:
  - Priority for the same obj_trd is kill > sleep > wake.
  - kill clears valid, run and park for obj_trd.
  - sleep clears run.
  - wake sets run only if valid is set; it is ignored otherwise.
  - Ops on different threads in the same cycle are impossible; kill/sleep/wake are one-hot.
- Allocation:
  - new_trd_id is the lowest index ≥1 with valid=0, taken from the registered mask. Slot 0 is never allocated.
  - trd_full=1 when slots 1..NUM_TRD-1 are all valid; new_trd_id=0 while full.
  - init_trd with !trd_full sets valid and run of new_trd_id.
  - init_trd with trd_full sets trd_of, which stays set until reset; no state change.
- Kill and init in the same cycle: a slot freed by kill is not reusable until the next cycle. If init and wake target the same slot, the result is valid=run=1.
- Park:
  - A miss sets park[t] and loads ctr[t]=MISS_WAIT.
  - ctr decrements each cycle while nonzero; on the 1→0 step park clears. The thread is therefore eligible again MISS_WAIT cycles after the miss.
  - A miss on an already-parked thread reloads the counter.
  - i_miss and d_miss in the same cycle park both threads; if they name the same thread, a single load.
  - A miss on an invalid thread is ignored.
- Killing thread 0 clears valid_trd[0]; the top level treats this as processor halt. Scheduling of the other threads continues.

Optional Feature:
- Macro: TRD_SCHED_PRIO_EN.
- Defined: thread 0 is granted whenever it is eligible and was not granted in the previous cycle. This overrides round-robin; the pointer is not updated on these priority grants.
- Undefined: pure round-robin as above.

Decomposition:
- Package trd_pkg:
  - NUM_TRD, TRD_W, MISS_WAIT_DEF.
  - typedef trd_id_t (logic [TRD_W-1:0]) and trd_mask_t (logic [NUM_TRD-1:0]).
  - Function first_zero_from1 for slot allocation.
- Sub-module rr_pick: combinational; inputs mask and pointer; outputs grant id and any-grant. Reused by the future D-port arbiter.
- Park counters and mask logic stay in trd_sched.

Test Plan:
- Reset, then init_trd twice → new_trd_id goes 1 then 2; valid_trd=8'h07; trd_if sequence 1,2,0,1,2,0 with trd_if_vld=1.
- d_miss with d_miss_trd=1 (MISS_WAIT=4) → park_trd[1]=1; thread 1 is absent from trd_if for 4 cycles, then rejoins the rotation.
- sleep obj=2, then wake obj=2 → thread 2 is skipped, then returns. wake obj=5 while valid[5]=0 → no change.
- Allocate slots 1..7 → trd_full=1, new_trd_id=0. A further init_trd → trd_of=1 and masks unchanged. kill obj=3 → next cycle trd_full=0, new_trd_id=3.
- stall held for 3 cycles mid-rotation → trd_if is frozen; on release the rotation resumes at the next thread. i_miss and d_miss on thread 0 in the same cycle → single park.
- Park all runnable threads → trd_if_vld=0. Assert rst_n=0 mid-park → all masks and counters return to their reset values.
